hpdcache_bin_decoder_pipe: RTL and testbench

HPDCACHE_BIN_DECODER_PIPE -- requirements
Module: hpdcache_bin_decoder_pipe

---
 rtl/hpdcache_bin_decoder_pipe.sv | 90 +++++++++
 tb/tb_hpdcache_bin_decoder_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_bin_decoder_pipe.sv
// Binary-to-one-hot decoder behind a 2-entry registered valid/ready buffer.
// Define HPDCACHE_BIN_DECODER_OOR_ERR_EN to flag out-of-range indices on err_o.
module hpdcache_bin_decoder_pipe #(
  parameter int N = 0,
  localparam int N_LOG2 = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N_LOG2-1:0] idx_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N-1:0]      onehot_o,
  output logic              err_o
);

  logic [N-1:0] oh_q [2];
  logic [N-1:0] oh_d;
  logic [1:0]   cnt_q;
  logic         wptr_q;
  logic         rptr_q;
  logic         push;
  logic         pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Indices >= N match no bit, so they decode to all zeros.
  always_comb begin
    oh_d = '0;
    for (int k = 0; k < N; k++) begin
      oh_d[k] = (idx_i == N_LOG2'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else if (flush_i) begin
      cnt_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oh_q[0] <= '0;
      oh_q[1] <= '0;
    end else if (push && !flush_i) begin
      oh_q[wptr_q] <= oh_d;
    end
  end

  assign onehot_o = valid_o ? oh_q[rptr_q] : '0;

`ifdef HPDCACHE_BIN_DECODER_OOR_ERR_EN
  logic [1:0] err_q;
  logic       oor;

  assign oor = ({1'b0, idx_i} >= (N_LOG2 + 1)'(N));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 2'b00;
    end else if (push && !flush_i) begin
      err_q[wptr_q] <= oor;
    end
  end

  assign err_o = valid_o && err_q[rptr_q];
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_bin_decoder_pipe.sv
// Scoreboard bench for hpdcache_bin_decoder_pipe (N = 6).
// Expected err depends on HPDCACHE_BIN_DECODER_OOR_ERR_EN.
module tb_hpdcache_bin_decoder_pipe;

  localparam int N = 6;
  localparam int NL = 3;

`ifdef HPDCACHE_BIN_DECODER_OOR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [NL-1:0] idx_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [N-1:0]  onehot_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  logic [N:0] q[$];

  hpdcache_bin_decoder_pipe #(.N(N)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .idx_i    (idx_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .onehot_o (onehot_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: {err, onehot} straight from the index value
  function automatic logic [N:0] model(input int idx);
    logic [N:0] r;
    r = '0;
    if (idx < N) r[idx] = 1'b1;
    else r[N] = ERR_EN;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      q.delete();
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_onehot", 32'(onehot_o), 0);
      chk("rst_err", 32'(err_o), 0);
    end else begin
      chk("sb_valid", 32'(valid_o), 32'(q.size() != 0));
      chk("sb_ready", 32'(ready_o), 32'(q.size() < 2));
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_pop", 1, 0);
        end else begin
          logic [N:0] e;
          e = q.pop_front();
          chk("sb_onehot", 32'(onehot_o), 32'(e[N-1:0]));
          chk("sb_err", 32'(err_o), 32'(e[N]));
        end
      end else if (!valid_o) begin
        chk("sb_idle_onehot", 32'(onehot_o), 0);
        chk("sb_idle_err", 32'(err_o), 0);
      end
      if (flush_i) q.delete();
      else if (valid_i && ready_o) q.push_back(model(int'(idx_i)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic r);
    valid_i = v;
    idx_i   = NL'(idx);
    ready_i = r;
  endtask

  initial begin
    #2;
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_ready", 32'(ready_o), 1);
    step();
    rst_ni = 1'b1;

    drive(1, 3, 1);
    step();
    chk("d030_valid", 32'(valid_o), 1);
    chk("d030_onehot", 32'(onehot_o), 32'h08);
    drive(0, 0, 1);
    step();
    chk("d030_empty", 32'(valid_o), 0);

    drive(1, 0, 0);
    step();
    drive(1, 5, 0);
    step();
    chk("d031_full", 32'(ready_o), 0);
    chk("d031_hold0", 32'(onehot_o), 32'h01);
    drive(1, 2, 0);
    step();
    chk("d031_still_full", 32'(ready_o), 0);
    chk("d031_hold1", 32'(onehot_o), 32'h01);

    drive(0, 0, 1);
    step();
    chk("d032_second", 32'(onehot_o), 32'h20);
    chk("d032_ready", 32'(ready_o), 1);
    step();
    chk("d032_empty", 32'(valid_o), 0);

    drive(1, 1, 0);
    step();
    chk("d033_head", 32'(onehot_o), 32'h02);
    drive(1, 4, 1);
    step();
    chk("d033_onehot", 32'(onehot_o), 32'h10);
    chk("d033_valid", 32'(valid_o), 1);
    chk("d033_ready", 32'(ready_o), 1);
    drive(0, 0, 1);
    step();
    chk("d033_occ1", 32'(valid_o), 0);

    drive(1, 7, 0);
    step();
    chk("d034_onehot", 32'(onehot_o), 0);
    chk("d034_err", 32'(err_o), 32'(ERR_EN));
    drive(0, 0, 1);
    step();
    chk("d034_empty", 32'(valid_o), 0);

    drive(1, 0, 0);
    step();
    step();
    chk("d035_full", 32'(ready_o), 0);
    drive(1, 2, 0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(0, 0, 0);
    chk("d035_flush_valid", 32'(valid_o), 0);
    chk("d035_flush_ready", 32'(ready_o), 1);

    drive(1, 3, 0);
    step();
    drive(0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("d035_rst_valid", 32'(valid_o), 0);
    chk("d035_rst_onehot", 32'(onehot_o), 0);
    chk("d035_rst_ready", 32'(ready_o), 1);
    step();
    rst_ni = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
      flush_i = ($urandom_range(0, 31) == 0);
      step();
    end
    flush_i = 1'b0;
    drive(0, 0, 1);
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", 32'(q.size()), 0);
    chk("drain_valid", 32'(valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
